// File: rtl/jesd204b_pkg.sv
// Constants and helpers shared by the JESD204B scrambler and descrambler.
// Polynomial is 1 + x^14 + x^15 with a 15-bit history register.
package jesd204b_pkg;

  localparam int SCR_POLY_TAP_A  = 14;
  localparam int SCR_POLY_TAP_B  = 15;
  localparam int SCR_HIST_W      = SCR_POLY_TAP_B;
  localparam logic [SCR_HIST_W-1:0] SCR_SEED = 15'h7f80;
  localparam int SCR_BYPASS_BITS = 16;

  typedef logic [SCR_HIST_W-1:0] scr_hist_t;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_BYPASS = 2'd1,
    MODE_DESCR  = 2'd2
  } descr_mode_e;

  // s[0] holds the most recent bit, so tap x^k lives at s[k-1].
  function automatic logic scr_feedback(input scr_hist_t s);
    return s[SCR_POLY_TAP_B-1] ^ s[SCR_POLY_TAP_A-1];
  endfunction

endpackage

// File: rtl/jesd204b_descr_core.sv
// Combinational word-wide unroll of the self-synchronising descrambler.
// Bits are walked MSB first; the received bit (not the output) feeds the history.
module jesd204b_descr_core
  import jesd204b_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int BYPASS_BITS = SCR_BYPASS_BITS
) (
  input  logic [DATA_WIDTH-1:0] in_word,
  input  scr_hist_t             s_in,
  output logic [DATA_WIDTH-1:0] d,
  output scr_hist_t             s_out
);

  scr_hist_t s;

  always_comb begin
    s = s_in;
    d = '0;
    for (int t = 0; t < DATA_WIDTH; t++) begin
      if (t < BYPASS_BITS) begin
        d[DATA_WIDTH-1-t] = in_word[DATA_WIDTH-1-t];
      end else begin
        d[DATA_WIDTH-1-t] = in_word[DATA_WIDTH-1-t] ^ scr_feedback(s);
      end
      s = {s[SCR_HIST_W-2:0], in_word[DATA_WIDTH-1-t]};
    end
    s_out = s;
  end

endmodule

// File: rtl/jesd204b_descrambler.sv
// JESD204B RX descrambler: registered output with valid, bypass mux and lock counter.
// One word per clock, one cycle of latency, no backpressure.
module jesd204b_descrambler
  import jesd204b_pkg::*;
#(
  parameter int              DATA_WIDTH  = 64,
  parameter int              BYPASS_BITS = SCR_BYPASS_BITS,
  parameter logic [14:0]     SEED        = SCR_SEED,
  parameter int              LOCK_WORDS  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  locked
);

  localparam logic [7:0] LOCK_MAX = 8'(LOCK_WORDS);

  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  locked_q, locked_d;
  scr_hist_t             hist_q, hist_d;
  logic [7:0]            lock_cnt_q, lock_cnt_d;

  logic [DATA_WIDTH-1:0] core_d;
  scr_hist_t             core_s;
  descr_mode_e           mode;

  jesd204b_descr_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYPASS_BITS(BYPASS_BITS)
  ) u_core (
    .in_word(in),
    .s_in   (hist_q),
    .d      (core_d),
    .s_out  (core_s)
  );

  always_comb begin
    mode = MODE_IDLE;
    if (in_valid) begin
      mode = en ? MODE_DESCR : MODE_BYPASS;
    end

    out_d       = out_q;
    out_valid_d = in_valid;
    hist_d      = hist_q;
    lock_cnt_d  = lock_cnt_q;

    case (mode)
      MODE_DESCR: begin
        out_d  = core_d;
        hist_d = core_s;
        if (lock_cnt_q != LOCK_MAX) begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
      end
      // Bypassed words are not part of the scrambled stream, so history is left alone.
      MODE_BYPASS: begin
        out_d      = in;
        lock_cnt_d = '0;
      end
      default: ;
    endcase

    locked_d = (lock_cnt_d == LOCK_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      hist_q      <= SEED;
      lock_cnt_q  <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      locked_q    <= locked_d;
      hist_q      <= hist_d;
      lock_cnt_q  <= lock_cnt_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_jesd204b_descrambler.sv
// Scoreboard bench: a bit-stream reference model predicts each word, monitors pop and compare.
// Second instance sweeps DATA_WIDTH=32, BYPASS_BITS=0 where the seed matters.
module tb_jesd204b_descrambler;
  import jesd204b_pkg::*;

  localparam int LW1 = 2;
  localparam int LW2 = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0, in_valid = 1'b0;
  logic [63:0] in_w = '0, out_w;
  logic        out_valid, locked;
  logic        en2 = 1'b1, in_valid2 = 1'b0;
  logic [31:0] in2 = '0, out2;
  logic        out_valid2, locked2;

  always #5 clk = ~clk;

  jesd204b_descrambler #(
    .DATA_WIDTH(64), .BYPASS_BITS(16), .SEED(15'h7f80), .LOCK_WORDS(LW1)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in(in_w),
    .out_valid(out_valid), .out(out_w), .locked(locked)
  );

  jesd204b_descrambler #(
    .DATA_WIDTH(32), .BYPASS_BITS(0), .SEED(15'h7f80), .LOCK_WORDS(LW2)
  ) dut2 (
    .clk(clk), .reset(reset), .en(en2), .in_valid(in_valid2), .in(in2),
    .out_valid(out_valid2), .out(out2), .locked(locked2)
  );

  typedef struct {
    logic [63:0] data;
    logic        lk;
  } exp_t;

  exp_t        exp1[$], exp2[$];
  int          checks = 0, errors = 0;
  logic [14:0] h1, h2, txh;
  int          cnt1, cnt2;
  logic        vexp1 = 1'b0, vexp2 = 1'b0;
  logic [63:0] hold1 = '0;
  logic [31:0] hold2 = '0;
  logic        hlk1 = 1'b0, hlk2 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: d[n] = r[n] ^ r[n-14] ^ r[n-15] over the whole received bit stream,
  // with the seed standing in for the 15 bits before the first word (h[14] oldest).
  function automatic logic [63:0] ref_descr(input logic [63:0] w, input int dw, input int bp,
                                           input logic [14:0] h, output logic [14:0] h_o);
    bit          q[$];
    logic [63:0] d;
    int          n;
    d = '0;
    for (int k = 14; k >= 0; k--) q.push_back(h[k]);
    for (int t = 0; t < dw; t++) begin
      n = q.size();
      q.push_back(w[dw-1-t]);
      d[dw-1-t] = (t < bp) ? w[dw-1-t] : (w[dw-1-t] ^ q[n-15] ^ q[n-14]);
    end
    for (int k = 0; k < 15; k++) h_o[k] = q[q.size()-1-k];
    return d;
  endfunction

  // Transmit scrambler model: scrambled bit s[n] = p[n] ^ s[n-14] ^ s[n-15].
  function automatic logic [63:0] tx_scr(input logic [63:0] p, input logic [14:0] h,
                                        output logic [14:0] h_o);
    bit          q[$];
    logic [63:0] s;
    int          n;
    bit          r;
    s = '0;
    for (int k = 14; k >= 0; k--) q.push_back(h[k]);
    for (int t = 0; t < 64; t++) begin
      n = q.size();
      r = (t < 16) ? p[63-t] : (p[63-t] ^ q[n-15] ^ q[n-14]);
      q.push_back(r);
      s[63-t] = r;
    end
    for (int k = 0; k < 15; k++) h_o[k] = q[q.size()-1-k];
    return s;
  endfunction

  task automatic model_reset();
    h1 = SCR_SEED;
    h2 = SCR_SEED;
    cnt1 = 0;
    cnt2 = 0;
  endtask

  task automatic drive(input logic v, input logic e, input logic [63:0] w,
                       input logic v2, input logic [31:0] w2,
                       input logic use_fix, input logic [63:0] fix);
    logic [14:0] hn;
    logic [63:0] m;
    exp_t        x;
    @(posedge clk);
    #1;
    in_valid  = v;
    en        = e;
    in_w      = w;
    in_valid2 = v2;
    in2       = w2;
    if (v) begin
      if (e) begin
        m  = ref_descr(w, 64, 16, h1, hn);
        h1 = hn;
        if (cnt1 < LW1) cnt1++;
        x.data = use_fix ? fix : m;
      end else begin
        cnt1   = 0;
        x.data = w;
      end
      x.lk = (cnt1 == LW1);
      exp1.push_back(x);
    end
    if (v2) begin
      m  = ref_descr({32'b0, w2}, 32, 0, h2, hn);
      h2 = hn;
      if (cnt2 < LW2) cnt2++;
      x.data = m;
      x.lk   = (cnt2 == LW2);
      exp2.push_back(x);
    end
  endtask

  // Reset is pulsed between edges; outputs must clear without a clock edge.
  task automatic pulse_reset();
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    #2;
    reset = 1'b1;
    exp1.delete();
    exp2.delete();
    model_reset();
    #1;
    chk("rst_out", out_w, 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_locked", 64'(locked), 64'h0);
    chk("rst_out2", 64'(out2), 64'h0);
    chk("rst_locked2", 64'(locked2), 64'h0);
    #3;
    reset = 1'b0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      vexp1 <= 1'b0;
      vexp2 <= 1'b0;
    end else begin
      vexp1 <= in_valid;
      vexp2 <= in_valid2;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      hold1 = '0;
      hlk1  = 1'b0;
      hold2 = '0;
      hlk2  = 1'b0;
    end else begin
      chk("out_valid", 64'(out_valid), 64'(vexp1));
      if (out_valid) begin
        if (exp1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%h required=none", out_w);
        end else begin
          e = exp1.pop_front();
          chk("data", out_w, e.data);
          chk("locked", 64'(locked), 64'(e.lk));
          hold1 = e.data;
          hlk1  = e.lk;
        end
      end else begin
        chk("hold_data", out_w, hold1);
        chk("hold_locked", 64'(locked), 64'(hlk1));
      end

      chk("out_valid2", 64'(out_valid2), 64'(vexp2));
      if (out_valid2) begin
        if (exp2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out2 actual=%h required=none", out2);
        end else begin
          e = exp2.pop_front();
          chk("data2", 64'(out2), e.data);
          chk("locked2", 64'(locked2), 64'(e.lk));
          hold2 = e.data[31:0];
          hlk2  = e.lk;
        end
      end else begin
        chk("hold_data2", 64'(out2), 64'(hold2));
        chk("hold_locked2", 64'(locked2), 64'(hlk2));
      end
    end
  end

  initial begin
    logic [63:0] p, s;
    logic [14:0] hn;
    logic        v;
    model_reset();
    txh = SCR_SEED;
    #2;
    chk("init_out", out_w, 64'h0);
    chk("init_out_valid", 64'(out_valid), 64'h0);
    chk("init_locked", 64'(locked), 64'h0);
    chk("init_out2", 64'(out2), 64'h0);
    #10;
    reset = 1'b0;

    // zero words descramble to zero; lock after LW1 words
    repeat (3) drive(1'b1, 1'b1, 64'h0, 1'b1, 32'h0, 1'b0, 64'h0);
    // single set bit at 61 reappears at 47 and 46 through the two taps
    drive(1'b1, 1'b1, 64'h2000_0000_0000_0000, 1'b1, $urandom, 1'b1, 64'h2000_C000_0000_0000);
    // bypass drops lock, re-enable needs LW1 words again
    drive(1'b1, 1'b0, 64'hDEAD_BEEF_0123_4567, 1'b0, 32'h0, 1'b1, 64'hDEAD_BEEF_0123_4567);
    repeat (3) drive(1'b1, 1'b1, {$urandom, $urandom}, 1'b1, $urandom, 1'b0, 64'h0);
    drive(1'b0, 1'b1, {$urandom, $urandom}, 1'b0, $urandom, 1'b0, 64'h0);
    drive(1'b1, 1'b1, {$urandom, $urandom}, 1'b1, $urandom, 1'b0, 64'h0);

    pulse_reset();
    drive(1'b1, 1'b1, {$urandom, $urandom}, 1'b1, 32'h0, 1'b0, 64'h0);
    drive(1'b1, 1'b1, {$urandom, $urandom}, 1'b1, $urandom, 1'b0, 64'h0);

    // loopback: scrambled payload must come back bit-exact, with valid gaps
    for (int i = 0; i < 1000; i++) begin
      v = ($urandom_range(3) != 0);
      if (v) begin
        p   = {$urandom, $urandom};
        s   = tx_scr(p, txh, hn);
        txh = hn;
        drive(1'b1, 1'b1, s, 1'($urandom_range(1)), $urandom, 1'b1, p);
      end else begin
        drive(1'b0, 1'b1, {$urandom, $urandom}, 1'($urandom_range(1)), $urandom, 1'b0, 64'h0);
      end
    end

    // random mix of en, valid and a mid-stream reset
    for (int i = 0; i < 300; i++) begin
      if (i == 150) pulse_reset();
      drive(1'($urandom_range(1)), ($urandom_range(3) != 0), {$urandom, $urandom},
            1'($urandom_range(1)), $urandom, 1'b0, 64'h0);
    end

    repeat (3) drive(1'b0, 1'b1, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0);
    @(posedge clk);
    #1;
    chk("drain1", 64'(exp1.size()), 64'h0);
    chk("drain2", 64'(exp2.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jesd204b_descrambler.md
Name: jesd204b_descrambler

Overview:
- Receive-side inverse of the JESD204B transmit scrambler.
- Self-synchronising descrambler for the polynomial 1 + x^14 + x^15, processing one DATA_WIDTH word per clock, MSB first.
- Sits between the RX link-layer lane alignment and the transport-layer deframer.
- Registers its output with a valid qualifier and reports a lock indication once its history register holds received data.

Parameters:
- DATA_WIDTH, 64, word width in bits; must be >= 16.
- BYPASS_BITS, 16, number of MSBs per word passed through unscrambled; matches the TX scrambler; must be <= DATA_WIDTH.
- SEED, 15'h7f80, reset value of the 15-bit history register.
- LOCK_WORDS, 2, number of consecutive descrambled valid words required before locked asserts; 1..255.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  1 = descramble; 0 = bypass (out = in).
- in_valid  in  1  qualifies in for this cycle.
- in  in  DATA_WIDTH  received scrambled word; bit DATA_WIDTH-1 is first on the wire.
- out_valid  out  1  registered copy of in_valid.
- out  out  DATA_WIDTH  descrambled word.
- locked  out  1  history register holds only received data and LOCK_WORDS words have been processed.

Behaviour:
- Reset (async assert, sync release): out=0, out_valid=0, locked=0, history s[14:0]=SEED, lock counter=0.
- Latency: exactly 1 clk. out and out_valid update on the edge after in/in_valid are sampled.
- No backpressure. Every cycle with in_valid=1 is consumed.
- Descramble, in_valid=1 and en=1:
  - Walk bits t=0..DATA_WIDTH-1 from MSB down; r_t = in[DATA_WIDTH-1-t].
  - For t < BYPASS_BITS: d_t = r_t.
  - Otherwise: d_t = r_t ^ s[14] ^ s[13].
  - After each bit: s = {s[13:0], r_t}. The received (scrambled) bit is shifted in, not d_t.
  - The final s is registered as history for the next word.
- With BYPASS_BITS >= 15, output is a function of the current word only. Carry-over history is still maintained for smaller BYPASS_BITS.
- en=0 with in_valid=1: out <= in; history unchanged; lock counter cleared; locked <= 0.
- in_valid=0: out holds its last value; out_valid <= 0; history and lock counter hold.
- Lock counter:
  - Increments on each in_valid & en cycle and saturates at LOCK_WORDS.
  - locked = (counter == LOCK_WORDS), registered.
  - Gaps in in_valid do not clear the counter.
- en toggling mid-stream takes effect for the word sampled in that cycle.
- Reset asserted mid-stream:
  - Outputs go to reset values immediately; an in-flight word is dropped.
  - First word after release is processed with history=SEED.

Decomposition:
- Shared package jesd204b_pkg holds:
  - SCR_POLY_TAP_A=14 and SCR_POLY_TAP_B=15.
  - SCR_SEED=15'h7f80.
  - SCR_BYPASS_BITS=16.
  - These constants are shared with the TX scrambler.
- One natural sub-module: jesd204b_descr_core. It is the combinational word-wide unroll taking (in, s_in) and producing (d, s_out). This block wraps it with the registers, enable mux and lock counter.

Test Plan:
- Reset then in=64'h0, in_valid=1, en=1 for 3 cycles -> out=64'h0 each word one cycle later; out_valid=1; locked=1 on the edge after the 2nd word.
- Single-bit word in=64'h2000_0000_0000_0000, en=1 -> out=64'h2000_C000_0000_0000 (bits 47,46 set by taps 14/15 of bit 61).
- Loopback: pseudo-random words through jesd204b_scrambler (DATA_WIDTH=64), then this block, with in_valid gaps -> out equals original payload bit-exact for 1000 words; out_valid tracks in_valid delayed 1.
- en=0, in=64'hDEAD_BEEF_0123_4567 -> out identical next cycle; locked drops to 0; re-enable requires LOCK_WORDS words to re-lock.
- Async reset pulsed between clock edges mid-stream -> out=0, out_valid=0, locked=0 without waiting for clk; next word after release descrambles correctly.
- Parameter sweep with BYPASS_BITS=0 and DATA_WIDTH=32 against the bit-serial reference model -> history carried across words; SEED affects the first 15 output bits only.
